sys_panel_cond: RTL and testbench
=================================

SYS_PANEL_COND -- requirements
Module: sys_panel_cond

Interface
REQ-001 Parameter NSW, default 4, number of front-panel switch channels (1..16).
REQ-002 Parameter DIV_LOG2, default 2, system clock divide exponent; divide ratio is 2^DIV_LOG2 (1..8).
REQ-003 Parameter DEB_BITS, default 16, debounce counter width; debounce interval is 2^DEB_BITS-1 EXTCLK cycles (2..24).
REQ-004 EXTCLK  input  1  board clock; all state updates on its rising edge.
REQ-005 RESETn  input  1  reset, asynchronous, active-low.
REQ-006 sw_IN  input  NSW  raw asynchronous switch levels, active-high.
REQ-007 SYSCLK  output  1  divided clock level, 50% duty.
REQ-008 SYSTICK  output  1  one-EXTCLK-cycle enable, once per SYSCLK period.
REQ-009 sw_LEVEL  output  NSW  debounced switch levels.
REQ-010 sw_PRESS  output  NSW  per-channel press pulse, aligned to SYSTICK.
REQ-011 sw_RELEASE  output  NSW  per-channel release pulse, aligned to SYSTICK.

Function
REQ-012 Divider: DIV_LOG2-bit up-counter, increments every EXTCLK cycle, wraps from all-ones to zero.
REQ-013 SYSCLK SHALL equal divider counter MSB, registered from the counter (no extra combinational path).
REQ-014 SYSTICK SHALL be high exactly in cycles where the divider counter equals all-ones; high for 1 of every 2^DIV_LOG2 cycles.
REQ-015 Each sw_IN bit SHALL pass a 2-flop synchronizer before any other use; synchronizer latency 2 cycles.
REQ-016 Per channel: DEB_BITS-bit counter; cleared when synchronized input equals sw_LEVEL; incremented otherwise.
REQ-017 When the counter reaches all-ones with input still differing, sw_LEVEL SHALL toggle next edge and counter clear.
REQ-018 Any input glitch shorter than 2^DEB_BITS-1 cycles SHALL clear the counter and never change sw_LEVEL.
REQ-019 A 0->1 sw_LEVEL change SHALL set a per-channel press-pending flag; 1->0 SHALL set a release-pending flag.
REQ-020 sw_PRESS[i] = press-pending[i] AND SYSTICK; the flag clears on that edge; same rule for sw_RELEASE.
REQ-021 Flag set and SYSTICK in same cycle: flag SHALL be set, pulse emitted on the following SYSTICK (no same-cycle bypass).
REQ-022 Press-pending and release-pending both set before a SYSTICK: both pulses SHALL emit on the same SYSTICK.
REQ-023 Repeated edge of same kind while pending: flag remains set; exactly one pulse (no counting).
REQ-024 Channels SHALL be fully independent; no arbitration between channels.

Reset
REQ-025 RESETn low SHALL asynchronously clear divider, synchronizers, debounce counters, sw_LEVEL, pending flags.
REQ-026 During reset: SYSCLK=0, SYSTICK=0, sw_LEVEL=0, sw_PRESS=0, sw_RELEASE=0.
REQ-027 Reset deassertion SHALL be synchronized internally (2-flop release) so first divider increment occurs on the 2nd EXTCLK edge after RESETn rises.
REQ-028 Reset mid-debounce or with pulses pending SHALL discard all progress; no pulse emitted after release.
REQ-029 A switch held high through reset SHALL produce one sw_PRESS after full debounce interval following release.

Verification
REQ-030 DIV_LOG2=2, free run 32 cycles -> SYSCLK period 4 cycles, 2 high/2 low; SYSTICK high every 4th cycle, 8 pulses.
REQ-031 DEB_BITS=4, sw_IN[0] rises and holds -> sw_LEVEL[0]=1 after 2+15+1 cycles; exactly one sw_PRESS[0] on next SYSTICK.
REQ-032 DEB_BITS=4, sw_IN[1] 10-cycle high glitch, repeated 3x with 2-cycle gaps -> sw_LEVEL[1] stays 0, no pulses.
REQ-033 Channels 0 and 3 debounce-complete in same cycle -> sw_PRESS=4'b1001 on a single SYSTICK.
REQ-034 DIV_LOG2=3, DEB_BITS=2, press then release completing before next SYSTICK -> sw_PRESS[0] and sw_RELEASE[0] both 1 on same SYSTICK, sw_LEVEL[0]=0.
REQ-035 RESETn pulsed low mid-debounce (counter=10 of 15) -> all outputs 0 immediately; restart requires full 15-cycle interval.

Source files
------------

// File: rtl/sys_panel_cond_if.sv
// Front-panel conditioner signal bundle: raw switch inputs plus divided clock,
// tick and debounced/edge outputs.
interface sys_panel_cond_if #(
  parameter int NSW = 4
);
  logic [NSW-1:0] sw_IN;
  logic           SYSCLK;
  logic           SYSTICK;
  logic [NSW-1:0] sw_LEVEL;
  logic [NSW-1:0] sw_PRESS;
  logic [NSW-1:0] sw_RELEASE;

  modport master (
    output sw_IN,
    input  SYSCLK, SYSTICK, sw_LEVEL, sw_PRESS, sw_RELEASE
  );

  modport slave (
    input  sw_IN,
    output SYSCLK, SYSTICK, sw_LEVEL, sw_PRESS, sw_RELEASE
  );
endinterface

// File: rtl/sys_panel_cond.sv
// Front-panel conditioner: clock divider with tick, per-switch synchronizer and
// debouncer, and press/release pulses aligned to the divided-clock tick.
module sys_panel_cond #(
  parameter int NSW      = 4,
  parameter int DIV_LOG2 = 2,
  parameter int DEB_BITS = 16
) (
  input logic             EXTCLK,
  input logic             RESETn,
  sys_panel_cond_if.slave pif
);
  localparam logic [DIV_LOG2-1:0] DIV_MAX = '1;
  localparam logic [DEB_BITS-1:0] DEB_MAX = '1;

  // run_q is the release flop; the state registers gated by it form the second stage.
  logic                run_q, run_d;
  logic [DIV_LOG2-1:0] div_q, div_d;
  logic [NSW-1:0]      sync0_q, sync0_d;
  logic [NSW-1:0]      sync1_q, sync1_d;
  logic [NSW-1:0]      level_q, level_d;
  logic [NSW-1:0]      press_q, press_d;
  logic [NSW-1:0]      rel_q, rel_d;
  logic [DEB_BITS-1:0] deb_q [NSW];
  logic [DEB_BITS-1:0] deb_d [NSW];
  logic                tick;

  assign tick = run_q && (div_q == DIV_MAX);

  always_comb begin
    run_d   = 1'b1;
    div_d   = div_q;
    sync0_d = sync0_q;
    sync1_d = sync1_q;
    level_d = level_q;
    press_d = press_q;
    rel_d   = rel_q;
    for (int i = 0; i < NSW; i++) deb_d[i] = deb_q[i];

    if (run_q) begin
      div_d   = div_q + DIV_LOG2'(1);
      sync0_d = pif.sw_IN;
      sync1_d = sync0_q;
      // Pending flags drain on the tick; a new edge in the same cycle re-arms them.
      press_d = press_q & ~{NSW{tick}};
      rel_d   = rel_q & ~{NSW{tick}};
      for (int i = 0; i < NSW; i++) begin
        if (sync1_q[i] == level_q[i]) begin
          deb_d[i] = '0;
        end else if (deb_q[i] == DEB_MAX) begin
          deb_d[i]   = '0;
          level_d[i] = ~level_q[i];
          if (level_q[i]) rel_d[i]   = 1'b1;
          else            press_d[i] = 1'b1;
        end else begin
          deb_d[i] = deb_q[i] + DEB_BITS'(1);
        end
      end
    end
  end

  always_ff @(posedge EXTCLK or negedge RESETn) begin
    if (!RESETn) begin
      run_q   <= 1'b0;
      div_q   <= '0;
      sync0_q <= '0;
      sync1_q <= '0;
      level_q <= '0;
      press_q <= '0;
      rel_q   <= '0;
      for (int i = 0; i < NSW; i++) deb_q[i] <= '0;
    end else begin
      run_q   <= run_d;
      div_q   <= div_d;
      sync0_q <= sync0_d;
      sync1_q <= sync1_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      for (int i = 0; i < NSW; i++) deb_q[i] <= deb_d[i];
    end
  end

  assign pif.SYSCLK     = div_q[DIV_LOG2-1];
  assign pif.SYSTICK    = tick;
  assign pif.sw_LEVEL   = level_q;
  assign pif.sw_PRESS   = press_q & {NSW{tick}};
  assign pif.sw_RELEASE = rel_q & {NSW{tick}};
endmodule

// File: tb/tb_sys_panel_cond.sv
// Randomized scoreboard bench for sys_panel_cond against a run-length reference model.
module tb_sys_panel_cond;
  localparam int NSW  = 4;
  localparam int DIVL = 3;
  localparam int DEBB = 2;
  localparam int NDIV = 1 << DIVL;
  localparam int NDEB = 1 << DEBB;   // consecutive differing cycles needed to flip a level

  logic EXTCLK = 1'b0;
  logic RESETn = 1'b0;
  sys_panel_cond_if #(.NSW(NSW)) pif ();

  sys_panel_cond #(.NSW(NSW), .DIV_LOG2(DIVL), .DEB_BITS(DEBB)) dut (
    .EXTCLK(EXTCLK),
    .RESETn(RESETn),
    .pif   (pif)
  );

  always #5 EXTCLK = ~EXTCLK;

  int total = 0;
  int bad   = 0;
  logic [13:0] exp_q [$];

  // reference model state
  bit             m_run;
  int             m_edges;
  logic [NSW-1:0] m_hist [2];
  logic [NSW-1:0] m_lvl, m_pp, m_rp;
  int             m_len [NSW];
  logic [NSW-1:0] cur_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic model_clear();
    m_run = 0; m_edges = 0; m_lvl = '0; m_pp = '0; m_rp = '0;
    m_hist[0] = '0; m_hist[1] = '0;
    for (int i = 0; i < NSW; i++) m_len[i] = 0;
  endtask

  // Apply one rising edge worth of behaviour, then queue the outputs expected after it.
  task automatic model_edge(input logic [NSW-1:0] in);
    bit tick_now;
    logic [NSW-1:0] sync;
    if (!RESETn) model_clear();
    else if (!m_run) m_run = 1;
    else begin
      tick_now = (m_edges % NDIV) == NDIV - 1;
      if (tick_now) begin m_pp = '0; m_rp = '0; end
      sync = m_hist[1];
      for (int i = 0; i < NSW; i++) begin
        if (sync[i] != m_lvl[i]) begin
          m_len[i]++;
          if (m_len[i] == NDEB) begin
            m_len[i] = 0;
            m_lvl[i] = ~m_lvl[i];
            if (m_lvl[i]) m_pp[i] = 1'b1; else m_rp[i] = 1'b1;
          end
        end else m_len[i] = 0;
      end
      m_hist[1] = m_hist[0];
      m_hist[0] = in;
      m_edges++;
    end
    begin
      bit t;
      bit sc;
      t  = m_run && ((m_edges % NDIV) == NDIV - 1);
      sc = (m_edges % NDIV) >= NDIV / 2;
      exp_q.push_back({sc, t, m_lvl, t ? m_pp : 4'b0, t ? m_rp : 4'b0});
    end
  endtask

  task automatic cyc(input logic r, input logic [NSW-1:0] v);
    @(negedge EXTCLK);
    RESETn     = r;
    cur_in     = v;
    pif.sw_IN  = v;
    model_edge(v);
    if (!r) begin
      #1;
      chk("rst_outputs", {pif.SYSCLK, pif.SYSTICK, pif.sw_LEVEL, pif.sw_PRESS, pif.sw_RELEASE}, 32'h0);
    end
  endtask

  task automatic hold(input int n, input logic [NSW-1:0] v);
    for (int k = 0; k < n; k++) cyc(1'b1, v);
  endtask

  // monitor: one expected output set per rising edge
  initial begin
    logic [13:0] e;
    forever begin
      @(posedge EXTCLK);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sysclk",  32'(pif.SYSCLK),     32'(e[13]));
        chk("systick", 32'(pif.SYSTICK),    32'(e[12]));
        chk("level",   32'(pif.sw_LEVEL),   32'(e[11:8]));
        chk("press",   32'(pif.sw_PRESS),   32'(e[7:4]));
        chk("release", 32'(pif.sw_RELEASE), 32'(e[3:0]));
      end
    end
  end

  initial begin
    logic [NSW-1:0] v;
    pif.sw_IN = '0;
    cur_in    = '0;
    model_clear();
    for (int k = 0; k < 3; k++) cyc(1'b0, 4'h0);
    hold(40, 4'h0);                              // free-running divider
    hold(20, 4'h1);                              // ch0 press
    for (int g = 0; g < 3; g++) begin            // ch1 glitches shorter than the interval
      hold(3, 4'h3);
      hold(2, 4'h1);
    end
    hold(16, 4'hD);                              // ch2 and ch3 complete together
    hold(16, 4'h0);
    for (int k = 0; k < 8; k++) begin            // quick press/release at varying phases
      hold(k, 4'h0);
      hold(4, 4'h1);
      hold(4, 4'h0);
      hold(12, 4'h0);
    end
    hold(3, 4'h1);                               // reset in the middle of a debounce
    for (int k = 0; k < 2; k++) cyc(1'b0, 4'h1);
    hold(24, 4'h1);                              // held through reset -> one press later
    hold(6, 4'h0);
    for (int k = 0; k < 2; k++) cyc(1'b0, 4'h0); // reset with a release pending
    hold(20, 4'h0);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        for (int k = 0; k <= int'($urandom_range(0, 2)); k++) cyc(1'b0, cur_in);
      end else begin
        v = cur_in;
        if ($urandom_range(0, 3) == 0) v = v ^ 4'($urandom_range(0, 15));
        cyc(1'b1, v);
      end
    end
    hold(20, 4'h0);
    @(negedge EXTCLK);
    @(negedge EXTCLK);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
